// File: rtl/dct_pkg.sv
// Shared definitions for the DCT quantizer and its sibling DCT/cosine blocks.
package dct_pkg;

    localparam int NBITS    = 16;
    localparam int MAX_LOG2 = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CALC,
        OUT
    } state_t;

    // Limit a requested pass length exponent to the largest supported one.
    function automatic logic [3:0] clamp_log2(input logic [3:0] req, input logic [3:0] max_log2);
        return (req > max_log2) ? max_log2 : req;
    endfunction

endpackage

// File: rtl/dct_quantize_if.sv
// Quantized output stream: valid/ready word with its coefficient index and end-of-pass marker.
interface dct_quantize_if #(
    parameter int NBITS  = dct_pkg::NBITS,
    parameter int ADDR_W = dct_pkg::MAX_LOG2
);
    logic                    out_valid;
    logic                    out_ready;
    logic signed [NBITS-1:0] out_data;
    logic [ADDR_W-1:0]       out_index;
    logic                    out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/q_mul_round.sv
// Multiply a coefficient by the reciprocal step, round half up, shift back to Q format and saturate.
module q_mul_round #(
    parameter int NBITS = dct_pkg::NBITS
) (
    input  logic signed [NBITS-1:0] coef,
    input  logic signed [NBITS-1:0] scale,
    input  logic [4:0]              frac,
    output logic signed [NBITS-1:0] result
);
    // One guard bit above the full product so the rounding add can never wrap.
    localparam int W = 2 * NBITS + 1;
    localparam logic signed [W-1:0] MAXV = (W'(1) <<< (NBITS - 1)) - W'(1);
    localparam logic signed [W-1:0] MINV = -(W'(1) <<< (NBITS - 1));

    logic signed [W-1:0] coef_x;
    logic signed [W-1:0] scale_x;
    logic signed [W-1:0] prod;
    logic signed [W-1:0] rnd;
    logic signed [W-1:0] sum;
    logic signed [W-1:0] shifted;

    // Full-precision product, half-LSB round, arithmetic shift, then clamp to the word range.
    always_comb begin
        coef_x  = W'(coef);
        scale_x = W'(scale);
        prod    = coef_x * scale_x;
        rnd     = '0;
        if (frac != 5'd0) begin
            rnd = W'(1) <<< (frac - 5'd1);
        end
        sum     = prod + rnd;
        shifted = sum >>> frac;
        if (shifted > MAXV) begin
            result = MAXV[NBITS-1:0];
        end else if (shifted < MINV) begin
            result = MINV[NBITS-1:0];
        end else begin
            result = shifted[NBITS-1:0];
        end
    end
endmodule

// File: rtl/dct_quantize.sv
// Reads DCT coefficients one at a time, quantizes each and streams them out with index and last flag.
module dct_quantize
    import dct_pkg::*;
#(
    parameter int NBITS    = dct_pkg::NBITS,
    parameter int MAX_LOG2 = dct_pkg::MAX_LOG2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [3:0]              log2_size,
    input  logic [4:0]              m_int,
    input  logic signed [NBITS-1:0] qscale,
    output logic [MAX_LOG2-1:0]     dct_addr,
    output logic                    dct_read,
    input  logic signed [NBITS-1:0] dct_readdata,
    input  logic                    dct_done,
    dct_quantize_if.master          out,
    output logic                    busy
);
    // One extra index bit so a full-size pass reaches its last index without wrapping.
    localparam int IDX_W = MAX_LOG2 + 1;

    state_t                  state;
    logic [IDX_W-1:0]        index;
    logic [IDX_W-1:0]        last_idx;
    logic [4:0]              frac_q;
    logic signed [NBITS-1:0] qscale_q;
    logic signed [NBITS-1:0] coef_q;
    logic signed [NBITS-1:0] q_result;

    q_mul_round #(.NBITS(NBITS)) u_mul (
        .coef   (coef_q),
        .scale  (qscale_q),
        .frac   (frac_q),
        .result (q_result)
    );

    // Pass sequencer: request, wait for data, quantize, hand off; all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            index         <= '0;
            last_idx      <= '0;
            frac_q        <= '0;
            qscale_q      <= '0;
            coef_q        <= '0;
            dct_read      <= 1'b0;
            dct_addr      <= '0;
            out.out_valid <= 1'b0;
            out.out_data  <= '0;
            out.out_index <= '0;
            out.out_last  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        qscale_q <= qscale;
                        frac_q   <= (m_int >= 5'(NBITS - 1)) ? 5'd0 : 5'(NBITS - 1) - m_int;
                        last_idx <= (IDX_W'(1) << clamp_log2(log2_size, 4'(MAX_LOG2))) - IDX_W'(1);
                        index    <= '0;
                        dct_addr <= '0;
                        dct_read <= 1'b1;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (dct_done) begin
                        coef_q   <= dct_readdata;
                        dct_read <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    out.out_data  <= q_result;
                    out.out_index <= index[MAX_LOG2-1:0];
                    out.out_last  <= (index == last_idx);
                    out.out_valid <= 1'b1;
                    state         <= OUT;
                end
                OUT: begin
                    if (out.out_ready) begin
                        out.out_valid <= 1'b0;
                        out.out_last  <= 1'b0;
                        if (out.out_last) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            index    <= index + IDX_W'(1);
                            dct_addr <= MAX_LOG2'(index + IDX_W'(1));
                            dct_read <= 1'b1;
                            state    <= REQ;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
